// File: rtl/conv_collect.sv
// conv_collect: buffers one conv feature map, checks its length, and replays it over valid/ready.
// Optional COLLECT_BINARIZE_EN sign-binarizes replayed words to +1/-1.
module conv_collect #(
    parameter int DW    = 32,
    parameter int DEPTH = 576,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          state,
    input  logic [DW-1:0] din,
    input  logic          ivalid,
    input  logic          idone,
    output logic [DW-1:0] dout,
    output logic          ovalid,
    input  logic          oready,
    output logic          olast,
    output logic          busy,
    output logic          err_len,
    output logic          err_ovf,
    output logic [AW-1:0] wcount
);
    typedef enum logic {COLLECT, DRAIN} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [AW-1:0] wcount_q, wcount_d, n_q, n_d, len_q, len_d, rptr_q, rptr_d, n_cur;
    logic [DW-1:0] dout_q, dout_d;
    logic          ovalid_q, ovalid_d, olast_q, olast_d, err_len_q, err_len_d, err_ovf_q, err_ovf_d;
    logic          we;
    logic [DW-1:0] mem [DEPTH];

    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w);
`ifdef COLLECT_BINARIZE_EN
        return w[DW-1] ? '1 : DW'(1);
`else
        return w;
`endif
    endfunction

    // frame size is taken from state on the first word and held for the rest of the frame
    assign n_cur = (wcount_q == '0) ? (state ? AW'(64) : AW'(576)) : n_q;

    always_comb begin
        fsm_d     = fsm_q;
        wcount_d  = wcount_q;
        n_d       = n_q;
        len_d     = len_q;
        rptr_d    = rptr_q;
        dout_d    = dout_q;
        ovalid_d  = ovalid_q;
        olast_d   = olast_q;
        err_len_d = err_len_q;
        err_ovf_d = err_ovf_q;
        we        = 1'b0;
        if (fsm_q == COLLECT) begin
            if (ivalid) begin
                n_d = n_cur;
                if (wcount_q < n_cur) begin
                    we       = 1'b1;
                    wcount_d = wcount_q + AW'(1);
                end else begin
                    err_ovf_d = 1'b1;
                end
                if (idone) begin
                    len_d     = wcount_d;
                    err_len_d = err_len_q | (wcount_d != n_cur);
                    rptr_d    = '0;
                    fsm_d     = DRAIN;
                end
            end
        end else begin
            err_ovf_d = err_ovf_q | ivalid;
            // output register refills on entry and on every non-final handshake
            if (!ovalid_q || (oready && !olast_q)) begin
                dout_d   = fmt(mem[rptr_q]);
                ovalid_d = 1'b1;
                olast_d  = rptr_q == len_q - AW'(1);
                rptr_d   = rptr_q + AW'(1);
            end else if (oready) begin
                ovalid_d = 1'b0;
                olast_d  = 1'b0;
                wcount_d = '0;
                fsm_d    = COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wcount_q] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q     <= COLLECT;
            wcount_q  <= '0;
            n_q       <= '0;
            len_q     <= '0;
            rptr_q    <= '0;
            dout_q    <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            wcount_q  <= wcount_d;
            n_q       <= n_d;
            len_q     <= len_d;
            rptr_q    <= rptr_d;
            dout_q    <= dout_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
            err_len_q <= err_len_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign dout    = dout_q;
    assign ovalid  = ovalid_q;
    assign olast   = olast_q;
    assign busy    = fsm_q == DRAIN;
    assign err_len = err_len_q;
    assign err_ovf = err_ovf_q;
    assign wcount  = wcount_q;
endmodule

// File: tb/tb_conv_collect.sv
// tb_conv_collect: directed vector table plus hand sequences for drain pulses, back-to-back frames and async reset.
module tb_conv_collect;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        state = 1'b0;
    logic [31:0] din = '0;
    logic        ivalid = 1'b0, idone = 1'b0, oready = 1'b0;
    logic [31:0] dout;
    logic        ovalid, olast, busy, err_len, err_ovf;
    logic [9:0]  wcount;
    int          n_cmp = 0, n_bad = 0;

    conv_collect dut (
        .clk(clk), .rstn(rstn), .state(state), .din(din), .ivalid(ivalid), .idone(idone),
        .dout(dout), .ovalid(ovalid), .oready(oready), .olast(olast), .busy(busy),
        .err_len(err_len), .err_ovf(err_ovf), .wcount(wcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st;
        int   n;
        int   mode;
        bit   tog;
        int   len;
        logic elen;
        logic eovf;
    } vec_t;

    vec_t v[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int mode, input int i);
        return mode == 1 ? ((i % 2 == 0) ? -32'sd5 : 32'sd3) : 32'(i);
    endfunction

    function automatic logic [31:0] expw(input int mode, input int i);
        logic [31:0] p;
        p = pat(mode, i);
`ifdef COLLECT_BINARIZE_EN
        return p[31] ? 32'hffff_ffff : 32'd1;
`else
        return p;
`endif
    endfunction

    task automatic do_reset();
        rstn = 1'b0; ivalid = 1'b0; idone = 1'b0; oready = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // called at a sample point; returns at the sample point of cycle T+1
    task automatic send_frame(input logic st, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            state = st; din = pat(mode, i); ivalid = 1'b1; idone = (i == n - 1);
            @(posedge clk); #1;
        end
        ivalid = 1'b0; idone = 1'b0;
        chk("busy_t1", busy, 1);
        chk("ovalid_t1", ovalid, 0);
    endtask

    // entered at T+1; returns at L+1 unless aborted after `abort` beats
    task automatic drain(input int len, input int mode, input bit tog, input int abort, input int pulse);
        int beats = 0;
        bit stall = 0, done = 0;
        logic [32:0] held = '0;
        for (int c = 0; c < 4 * len + 20 && !done; c++) begin
            @(posedge clk); #1;
            ivalid = (c == pulse); din = 32'd999;
            if (c == 0) chk("ovalid_t2", ovalid, 1);
            if (stall) chk("hold", {olast, dout}, held);
            oready = tog ? (c % 2 == 0) : 1'b1;
            stall = ovalid && !oready;
            held = {olast, dout};
            if (ovalid && oready) begin
                chk("beat_data", dout, expw(mode, beats));
                chk("beat_last", olast, beats == len - 1);
                beats++;
                if (olast) done = 1;
                if (abort != 0 && beats == abort) return;
            end
        end
        ivalid = 1'b0;
        if (!done) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
        oready = 1'b0;
        chk("busy_l1", busy, 0);
        chk("ovalid_l1", ovalid, 0);
        chk("wcount_l1", wcount, 0);
        chk("beats", beats, len);
    endtask

    initial begin
        v[0] = '{1'b0, 576, 0, 1'b0, 576, 1'b0, 1'b0};
        v[1] = '{1'b1, 64, 1, 1'b1, 64, 1'b0, 1'b0};
        v[2] = '{1'b1, 60, 0, 1'b0, 60, 1'b1, 1'b0};
        v[3] = '{1'b1, 66, 0, 1'b0, 64, 1'b0, 1'b1};
        v[4] = '{1'b1, 1, 1, 1'b0, 1, 1'b1, 1'b0};
        v[5] = '{1'b0, 10, 1, 1'b1, 10, 1'b1, 1'b0};

        #2;
        chk("rst_dout", dout, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_olast", olast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_wcount", wcount, 0);
        do_reset();

        idone = 1'b1;
        @(posedge clk); #1;
        idone = 1'b0;
        chk("idone_alone_busy", busy, 0);
        chk("idone_alone_wcount", wcount, 0);

        for (int k = 0; k < 6; k++) begin
            do_reset();
            send_frame(v[k].st, v[k].n, v[k].mode);
            chk("wcount_t1", wcount, v[k].len);
            drain(v[k].len, v[k].mode, v[k].tog, 0, -1);
            chk("err_len", err_len, v[k].elen);
            chk("err_ovf", err_ovf, v[k].eovf);
        end

        do_reset();
        send_frame(1'b1, 64, 0);
        drain(64, 0, 1'b0, 0, 5);
        chk("pulse_err_ovf", err_ovf, 1);
        chk("pulse_err_len", err_len, 0);
        send_frame(1'b1, 64, 1);
        drain(64, 1, 1'b1, 0, -1);
        chk("b2b_err_len", err_len, 0);

        do_reset();
        send_frame(1'b0, 576, 0);
        drain(576, 0, 1'b0, 100, -1);
        rstn = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_ovalid", ovalid, 0);
        chk("arst_olast", olast, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wcount", wcount, 0);
        @(posedge clk); #1;
        rstn = 1'b1; oready = 1'b0;
        @(posedge clk); #1;
        send_frame(1'b1, 64, 0);
        drain(64, 0, 1'b0, 0, -1);
        chk("arst_err_len", err_len, 0);
        chk("arst_err_ovf", err_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
